// File: rtl/sha_pkg.sv
// ---------------------------------------------------------------------------
// sha_pkg
//   Shared definitions for the SHA working/chaining register bank.
//   - Word width and round count constants for the SHA-256 and SHA-512 modes
//   - Compression sequencer state encoding
//   - SHA-256 initial hash value, H0 in the least significant word
// ---------------------------------------------------------------------------
package sha_pkg;

    localparam int SHA256_WORD_W = 32;
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_WORD_W = 64;
    localparam int SHA512_ROUNDS = 80;

    // A..H and H0..H7 are both eight words wide
    localparam int NUM_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } sha_state_e;

    // SHA-256 IV packed as {H7, ..., H0}
    localparam logic [NUM_WORDS*SHA256_WORD_W-1:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

endpackage

// File: rtl/sha_word_reg.sv
// ---------------------------------------------------------------------------
// sha_word_reg
//   One WORD_W-wide register with synchronous active-high reset and a load
//   enable. The bank builds both the working variables and the chaining words
//   out of these.
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous reset, active high, clears q
//     ld   - load enable
//     d    - next value
//     q    - current value
// ---------------------------------------------------------------------------
module sha_word_reg #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sha_work_reg_bank.sv
// ---------------------------------------------------------------------------
// sha_work_reg_bank
//   Working variables A..H plus chaining words H0..H7 for one SHA compression
//   block, with the sequencer that loads, runs NUM_ROUNDS shift-updates and
//   performs the feed-forward add. Round arithmetic (T1/T2, K/W lookup) is
//   external; this block only presents A..H and the round index and consumes
//   the two new words the round logic produces.
//   Ports:
//     CLK, RST     - clock (rising edge), synchronous active-high reset
//     init_i       - load H0..H7 from iv_i (new message)
//     iv_i         - initial hash value, H0 at LSBs
//     start        - begin compressing one block
//     stall_i      - freeze the round in progress
//     new_a_i      - next A (T1+T2)
//     new_e_i      - next E (D+T1)
//     work_o       - A..H, A at LSBs
//     round_idx_o  - round being computed; 0 outside ROUND
//     busy_o       - high in ROUND and FINAL
//     done_o       - one-cycle pulse once hash_o holds the new digest
//     hash_o       - H0..H7, H0 at LSBs
// ---------------------------------------------------------------------------
module sha_work_reg_bank
    import sha_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64,
    parameter int CNT_W      = 7
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          init_i,
    input  logic [NUM_WORDS*WORD_W-1:0]   iv_i,
    input  logic                          start,
    input  logic                          stall_i,
    input  logic [WORD_W-1:0]             new_a_i,
    input  logic [WORD_W-1:0]             new_e_i,
    output logic [NUM_WORDS*WORD_W-1:0]   work_o,
    output logic [CNT_W-1:0]              round_idx_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NUM_WORDS*WORD_W-1:0]   hash_o
);

    // Elaboration-time parameter sanity
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha_work_reg_bank: WORD_W must be 32 or 64");
    end
    if (NUM_ROUNDS < 1 || CNT_W < $clog2(NUM_ROUNDS)) begin : g_bad_cnt_w
        $error("sha_work_reg_bank: CNT_W too narrow for NUM_ROUNDS");
    end

    // Index 0 = A / H0, index 7 = H / H7
    logic [NUM_WORDS-1:0][WORD_W-1:0] iv_w;
    logic [NUM_WORDS-1:0][WORD_W-1:0] work_q, work_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] hash_q, hash_d;
    logic                             work_ld, hash_ld;

    sha_state_e       state;
    logic [CNT_W-1:0] rnd;
    logic             busy_q;
    logic             done_q;

    logic blk_start;
    logic round_adv;
    logic last_rnd;

    assign iv_w      = iv_i;
    assign blk_start = (state == IDLE) && start;
    assign round_adv = (state == ROUND) && !stall_i;
    assign last_rnd  = (rnd == CNT_W'(NUM_ROUNDS - 1));

    // ------------------------------------------------------------------
    // Working-variable next value: load on start, shift on each live round.
    // A..D and E..H are two four-deep shift chains fed by new_a / new_e.
    // ------------------------------------------------------------------
    always_comb begin
        work_ld   = blk_start || round_adv;
        work_d[0] = new_a_i;
        work_d[1] = work_q[0];
        work_d[2] = work_q[1];
        work_d[3] = work_q[2];
        work_d[4] = new_e_i;
        work_d[5] = work_q[4];
        work_d[6] = work_q[5];
        work_d[7] = work_q[6];
        if (state == IDLE) begin
            // A simultaneous init takes the IV directly, since H is only
            // being written on this same edge.
            work_d = init_i ? iv_w : hash_q;
        end
    end

    // ------------------------------------------------------------------
    // Chaining-word next value: IV load in IDLE, feed-forward in FINAL.
    // Sums wrap mod 2^WORD_W; the carry is simply dropped.
    // ------------------------------------------------------------------
    always_comb begin
        hash_ld = ((state == IDLE) && init_i) || (state == FINAL);
        for (int i = 0; i < NUM_WORDS; i++) begin
            hash_d[i] = (state == FINAL) ? (hash_q[i] + work_q[i]) : iv_w[i];
        end
    end

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
        sha_word_reg #(.WORD_W(WORD_W)) u_work (
            .CLK (CLK),
            .RST (RST),
            .ld  (work_ld),
            .d   (work_d[gi]),
            .q   (work_q[gi])
        );
        sha_word_reg #(.WORD_W(WORD_W)) u_hash (
            .CLK (CLK),
            .RST (RST),
            .ld  (hash_ld),
            .d   (hash_d[gi]),
            .q   (hash_q[gi])
        );
    end

    // ------------------------------------------------------------------
    // Sequencer. The round counter is cleared on the last round so it
    // already reads 0 in FINAL and stays 0 through IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            rnd    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ROUND;
                        rnd    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ROUND: begin
                    if (!stall_i) begin
                        if (last_rnd) begin
                            state <= FINAL;
                            rnd   <= '0;
                        end else begin
                            rnd <= rnd + CNT_W'(1);
                        end
                    end
                end
                FINAL: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    rnd    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign work_o      = work_q;
    assign hash_o      = hash_q;
    assign round_idx_o = rnd;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_sha_work_reg_bank.sv
module tb_sha_work_reg_bank;
    import sha_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- 32-bit instance ----------------
    logic            rst, init, start, stall;
    logic [7:0][31:0] iv, work, hash;
    logic [31:0]     na, ne;
    logic [6:0]      ridx;
    logic            busy, done;

    sha_work_reg_bank #(.WORD_W(32), .NUM_ROUNDS(64), .CNT_W(7)) u_dut (
        .CLK(CLK), .RST(rst), .init_i(init), .iv_i(iv), .start(start),
        .stall_i(stall), .new_a_i(na), .new_e_i(ne), .work_o(work),
        .round_idx_o(ridx), .busy_o(busy), .done_o(done), .hash_o(hash)
    );

    // ---------------- 64-bit instance ----------------
    logic            rst_w, init_w, start_w, stall_w;
    logic [7:0][63:0] iv_w, work_w, hash_w;
    logic [63:0]     na_w, ne_w;
    logic [6:0]      ridx_w;
    logic            busy_w, done_w;

    sha_work_reg_bank #(.WORD_W(64), .NUM_ROUNDS(80), .CNT_W(7)) u_dut64 (
        .CLK(CLK), .RST(rst_w), .init_i(init_w), .iv_i(iv_w), .start(start_w),
        .stall_i(stall_w), .new_a_i(na_w), .new_e_i(ne_w), .work_o(work_w),
        .round_idx_o(ridx_w), .busy_o(busy_w), .done_o(done_w), .hash_o(hash_w)
    );

    // ---------------- reference data ----------------
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] ABC_DIGEST = {
        32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
        32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
    };

    logic [31:0] Wm [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Working variables after n rounds of the index-pattern round driver
    function automatic logic [7:0][31:0] pat_work(input int n);
        logic [7:0][31:0] w;
        w = SHA256_IV;
        for (int r = 0; r < n; r++) begin
            w = {w[6], w[5], w[4], 32'h100 + 32'(r), w[2], w[1], w[0], 32'(r + 1)};
        end
        return w;
    endfunction

    function automatic logic [7:0][31:0] pat_hash();
        logic [7:0][31:0] w, iv0, h;
        w   = pat_work(64);
        iv0 = SHA256_IV;
        for (int i = 0; i < 8; i++) h[i] = iv0[i] + w[i];
        return h;
    endfunction

    // ---------------- external round logic model ----------------
    localparam int M_ZERO = 0, M_PAT = 1, M_SHA = 2;
    int mode = M_ZERO;
    logic [31:0] t1, t2;

    always_comb begin
        t1 = '0;
        t2 = '0;
        na = '0;
        ne = '0;
        if (mode == M_PAT) begin
            na = 32'(ridx) + 32'd1;
            ne = 32'h100 + 32'(ridx);
        end else if (mode == M_SHA) begin
            t1 = work[7] + (rotr(work[4], 6) ^ rotr(work[4], 11) ^ rotr(work[4], 25))
               + ((work[4] & work[5]) ^ (~work[4] & work[6]))
               + K[ridx[5:0]] + Wm[ridx[5:0]];
            t2 = (rotr(work[0], 2) ^ rotr(work[0], 13) ^ rotr(work[0], 22))
               + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));
            na = t1 + t2;
            ne = work[3] + t1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [511:0] hash;
        int           cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q32.size() == 0) begin
                n_chk++;
                $display("FAIL done32_unexpected: got done_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = q32.pop_front();
                chk("done32_cycle", 512'(cyc), 512'(e.cyc));
                chk("hash32", 512'(hash), e.hash);
                chk("ridx32_at_done", 512'(ridx), 512'(0));
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (done_w === 1'b1) begin
            if (q64.size() == 0) begin
                n_chk++;
                $display("FAIL done64_unexpected: got done_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = q64.pop_front();
                chk("done64_cycle", 512'(cyc), 512'(e.cyc));
                chk("hash64", 512'(hash_w), e.hash);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start32(input logic [255:0] v, input bit expect_done,
                           input logic [255:0] exp_h, input int stalls);
        exp_t e;
        iv    = v;
        init  = 1'b1;
        start = 1'b1;
        if (expect_done) begin
            e.hash = 512'(exp_h);
            e.cyc  = cyc + 1 + 64 + 1 + stalls;
            q32.push_back(e);
        end
        @(negedge CLK);
        init  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_ridx(input int r);
        int n = 0;
        while (ridx != 7'(r) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (ridx != 7'(r)) begin
            n_chk++;
            $display("FAIL wait_ridx: got timeout, expected round %0d", r);
        end
    endtask

    task automatic wait_q32();
        int n = 0;
        while (q32.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (q32.size() != 0) begin
            n_chk++;
            $display("FAIL done32_timeout: got no done_o, expected %0d pending", q32.size());
            q32.delete();
        end
        @(negedge CLK);
    endtask

    task automatic wait_q64();
        int n = 0;
        while (q64.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (q64.size() != 0) begin
            n_chk++;
            $display("FAIL done64_timeout: got no done_o, expected %0d pending", q64.size());
            q64.delete();
        end
        @(negedge CLK);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0][31:0] w10;
        logic [7:0][63:0] h1, h2;
        exp_t e;
        int   n;

        rst = 1'b1; init = 1'b0; start = 1'b0; stall = 1'b0; iv = '0;
        rst_w = 1'b1; init_w = 1'b0; start_w = 1'b0; stall_w = 1'b0; iv_w = '0;
        na_w = '0; ne_w = '0;

        // Message schedule for the single padded block "abc"
        for (int i = 0; i < 16; i++) Wm[i] = '0;
        Wm[0]  = 32'h61626380;
        Wm[15] = 32'h00000018;
        for (int i = 16; i < 64; i++) begin
            Wm[i] = (rotr(Wm[i-2], 17) ^ rotr(Wm[i-2], 19) ^ (Wm[i-2] >> 10)) + Wm[i-7]
                  + (rotr(Wm[i-15], 7) ^ rotr(Wm[i-15], 18) ^ (Wm[i-15] >> 3)) + Wm[i-16];
        end

        // Reset and idle
        repeat (2) @(negedge CLK);
        chk("rst_work", 512'(work), 512'(0));
        chk("rst_hash", 512'(hash), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_ridx", 512'(ridx), 512'(0));
        chk("rst_hash64", 512'(hash_w), 512'(0));
        rst = 1'b0;
        rst_w = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_busy", 512'(busy), 512'(0));
        chk("idle_work", 512'(work), 512'(0));

        // Shift-register path with index-pattern round words
        mode = M_PAT;
        start32(SHA256_IV, 1'b1, pat_hash(), 0);
        chk("busy_round", 512'(busy), 512'(1));
        @(negedge CLK);
        chk("r0_A", 512'(work[0]), 512'(32'h1));
        chk("r0_B", 512'(work[1]), 512'(32'h6a09e667));
        chk("r0_E", 512'(work[4]), 512'(32'h100));
        chk("r0_F", 512'(work[5]), 512'(32'h510e527f));
        chk("r0_ridx", 512'(ridx), 512'(1));
        wait_q32();
        chk("pat_H0", 512'(hash[0]), 512'(32'h6a09e667 + 32'd64));

        // Stall three cycles at round 10
        start32(SHA256_IV, 1'b1, pat_hash(), 3);
        wait_ridx(10);
        w10 = pat_work(10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_ridx", 512'(ridx), 512'(10));
            chk("stall_work", 512'(work), 512'(w10));
        end
        stall = 1'b0;
        wait_q32();

        // Full "abc" digest, with init/start pulsed mid-block (must be ignored)
        mode = M_SHA;
        start32(SHA256_IV, 1'b1, ABC_DIGEST, 0);
        wait_ridx(20);
        chk("busy_mid", 512'(busy), 512'(1));
        iv    = {8{32'hdeadbeef}};
        init  = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        init  = 1'b0;
        start = 1'b0;
        iv    = SHA256_IV;
        chk("ignored_ridx", 512'(ridx), 512'(21));
        wait_q32();
        chk("abc_hold", 512'(hash), 512'(ABC_DIGEST));

        // Abort at round 30
        mode = M_PAT;
        start32(SHA256_IV, 1'b0, '0, 0);
        wait_ridx(30);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        chk("abort_work", 512'(work), 512'(0));
        chk("abort_hash", 512'(hash), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_done", 512'(done), 512'(0));
        chk("abort_ridx", 512'(ridx), 512'(0));
        repeat (80) @(negedge CLK);
        chk("abort_still_idle", 512'(busy), 512'(0));

        // Wide mode, back-to-back blocks, mod 2^64 wrap
        for (int i = 0; i < 8; i++) begin
            h1[i] = (i < 4) ? 64'd0 : 64'd1;
            h2[i] = (i < 4) ? 64'd1 : 64'd3;
        end
        iv_w   = {8{64'hffff_ffff_ffff_ffff}};
        na_w   = 64'd1;
        ne_w   = 64'd2;
        init_w = 1'b1;
        start_w = 1'b1;
        e.hash = 512'(h1);
        e.cyc  = cyc + 1 + 81;
        q64.push_back(e);
        @(negedge CLK);
        init_w  = 1'b0;
        start_w = 1'b0;
        n = 0;
        while (done_w !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (done_w !== 1'b1) begin
            n_chk++;
            $display("FAIL done64_first: got timeout, expected done_o");
        end else begin
            chk("wrap_H0", 512'(hash_w[0]), 512'(64'd0));
            start_w = 1'b1;
            e.hash = 512'(h2);
            e.cyc  = cyc + 1 + 81;
            q64.push_back(e);
            @(negedge CLK);
            start_w = 1'b0;
            chk("chain_busy", 512'(busy_w), 512'(1));
        end
        wait_q64();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha_work_reg_bank.md
Name: sha_work_reg_bank

Overview:
- Parametrised successor of the single load-enable working register.
- Holds the eight SHA working variables A..H and the eight chaining words H0..H7.
- Sequences one compression block: load, NUM_ROUNDS shift-updates, then feed-forward add.
- Sits between the external combinational round logic (T1/T2, K/W lookup) and the digest output.
- One instance serves SHA-256 (WORD_W=32, NUM_ROUNDS=64) or SHA-512 (WORD_W=64, NUM_ROUNDS=80).

Parameters:
- WORD_W, 32, word width in bits; legal values 32 or 64.
- NUM_ROUNDS, 64, rounds per block; 64 for SHA-256, 80 for SHA-512.
- CNT_W, 7, round counter width; must satisfy 2^CNT_W >= NUM_ROUNDS.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- init_i  in  1  load chaining words H0..H7 from iv_i (start of a new message).
- iv_i  in  8*WORD_W  initial hash value; word 0 (H0) at LSBs.
- start  in  1  begin compression of one block.
- stall_i  in  1  freeze the round in progress (message schedule word not ready).
- new_a_i  in  WORD_W  next A (T1+T2) from the round logic.
- new_e_i  in  WORD_W  next E (D+T1) from the round logic.
- work_o  out  8*WORD_W  current A..H; A at LSBs.
- round_idx_o  out  CNT_W  index of the round being computed, for K/W selection.
- busy_o  out  1  high in ROUND and FINAL.
- done_o  out  1  one-cycle pulse; hash_o is updated.
- hash_o  out  8*WORD_W  chaining words H0..H7.

Behaviour:
- Reset is synchronous and active-high. The clock is CLK and the reset is RST.
- Values while RST is high at a CLK edge: state=IDLE, work_o=0, hash_o=0, round_idx_o=0, busy_o=0, done_o=0.
- RST asserted mid-block aborts the block with no partial feed-forward. H is cleared.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - init_i=1 loads H<=iv_i.
  - start=1 loads work<=H, or work<=iv_i if init_i is also 1 in the same cycle (new single-block message). It then clears round_idx and moves to ROUND.
  - init_i=1 and start=1 together load both H and work from iv_i.
- ROUND:
  - When stall_i=0, each cycle performs the update:
    - H<=G, G<=F, F<=E, E<=new_e_i
    - D<=C, C<=B, B<=A, A<=new_a_i
    - round_idx++
  - When round_idx==NUM_ROUNDS-1 and stall_i=0, the update is applied and the state goes to FINAL.
  - When stall_i=1, work and round_idx hold.
  - new_a_i and new_e_i are sampled only in non-stalled ROUND cycles.
- FINAL:
  - Hi<=Hi+work_i for i=0..7, each add mod 2^WORD_W with the carry discarded.
  - work holds.
  - Next state is IDLE, and done_o=1 in that next cycle.
  - stall_i is ignored in FINAL.
- Latency: start is sampled at edge t. done_o is high during cycle t+NUM_ROUNDS+1 plus the number of stalled cycles (t+65 for SHA-256 with no stalls). In that cycle hash_o already holds the new value.
- While busy_o=1, start and init_i are ignored. A start in the same cycle done_o is high is accepted and chains blocks back-to-back.
- round_idx_o never exceeds NUM_ROUNDS-1. It reads 0 in IDLE and FINAL.

Decomposition:
- Shared package sha_pkg holds:
  - word-width and round-count constants for the SHA-256 and SHA-512 modes;
  - the state enum (IDLE, ROUND, FINAL);
  - the SHA-256 IV constants for test benches.
- One natural sub-module: sha_word_reg. It is a WORD_W-wide register with synchronous reset and load enable, instantiated 16 times (8 working + 8 chaining). The FSM, counter and adders stay in the top module.

Test Plan:
- Reset and idle:
  - Stimulus: RST=1 for 2 cycles, then idle with start=0.
  - Response: work_o=0, hash_o=0, busy_o=0, done_o=0, round_idx_o=0.
- Shift-register path:
  - Stimulus: init_i+start with iv_i = SHA-256 IV (H0=32'h6a09e667 … H7=32'h5be0cd19). Drive new_a_i=round_idx+1 and new_e_i=32'h100+round_idx.
  - Response after round 0: A=1, B=6a09e667, E=32'h100, F=510e527f.
  - Response: done_o at t+65.
  - Response: H0 = 6a09e667+64 (mod 2^32), with the other words per the reference model.
- Full digest:
  - Stimulus: bench round model with padded "abc".
  - Response: hash_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Stall:
  - Stimulus: stall_i=1 for 3 cycles at round 10.
  - Response: round_idx_o holds at 10 and work_o is unchanged; done_o is at t+68.
- Abort and ignored commands:
  - Stimulus: start and init_i pulsed while busy.
  - Response: ignored, and the digest is unchanged.
  - Stimulus: RST at round 30.
  - Response: next cycle state is IDLE with all outputs 0 and no done_o.
- Wide mode with back-to-back blocks:
  - Stimulus: WORD_W=64, NUM_ROUNDS=80, start issued in the cycle done_o is high.
  - Response: done_o pulses at t+81 and t+162, and FINAL wraps mod 2^64 (H0=all-ones plus A=1 gives 0).
